y86_seq_ctrl: RTL and testbench
===============================

Y86_SEQ_CTRL -- requirements
Module: y86_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning PC and address width.
REQ-002 SHALL have parameter CNT_W, default 32, meaning retired-instruction counter width.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning max cycles waiting for a memory ack (range 1..255).
REQ-004 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n_i  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port imem_ack_i  in  1  instruction fetch complete; icode_i, instr_valid_i and imem_error_i are valid in this cycle.
REQ-007 SHALL have port icode_i  in  4  decoded icode from fetch.
REQ-008 SHALL have port instr_valid_i / imem_error_i  in  1 each  fetch status.
REQ-009 SHALL have port dmem_ack_i / dmem_error_i  in  1 each  data-access complete / data-address fault.
REQ-010 SHALL have port cnd_i  in  1  branch condition from execute.
REQ-011 SHALL have port valC_i, valP_i, valM_i  in  ADDR_W each  next-PC candidates.
REQ-012 SHALL have port pc_o  out  ADDR_W  current PC.
REQ-013 SHALL have port imem_req_o, dmem_req_o, dmem_wr_o  out  1 each  memory request strobes; dmem_wr_o=1 selects write.
REQ-014 SHALL have port cc_we_o, reg_we_o  out  1 each  condition-code / register-file write enables.
REQ-015 SHALL have port stat_o  out  2  00 AOK, 01 HLT, 10 ADR, 11 INS.
REQ-016 SHALL have port state_o  out  3  current FSM state encoding.
REQ-017 SHALL have port retired_o  out  CNT_W  retired-instruction count.

Function
REQ-018 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRBACK=4, PCUPD=5, STOP=6, with state_o equal to the encoding.
REQ-019 FETCH SHALL hold imem_req_o=1 until imem_ack_i; on ack go to DECODE, except imem_error_i -> STOP with stat ADR, else !instr_valid_i -> STOP with stat INS.
REQ-020 DECODE SHALL latch icode_i, taken from the ack cycle; icode 0 (halt) -> STOP with stat HLT and PC unchanged; otherwise -> EXECUTE.
REQ-021 EXECUTE SHALL last one cycle and assert cc_we_o for that cycle iff icode==6 (OPq).
REQ-022 From EXECUTE, icode in {4,5,8,9,A,B} SHALL go to MEMORY; all other icodes SHALL go to WRBACK.
REQ-023 MEMORY SHALL hold dmem_req_o=1 until dmem_ack_i, with dmem_wr_o=1 for icodes {4,8,A} and 0 for {5,9,B}; dmem_error_i on ack -> STOP with stat ADR.
REQ-024 WRBACK SHALL last one cycle and assert reg_we_o iff icode in {2,3,5,6,8,9,A,B}.
REQ-025 PCUPD SHALL load pc_o with valC_i when icode==8, or when icode==7 and cnd_i=1; with valM_i when icode==9; otherwise with valP_i.
REQ-026 PCUPD SHALL increment retired_o by 1 (wrapping modulo 2^CNT_W) and then go to FETCH.
REQ-027 A wait counter SHALL clear on entry to FETCH or MEMORY and increment each un-acked request cycle; reaching TIMEOUT without ack -> STOP with stat ADR.
REQ-028 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL win: it is treated as a normal ack, not a timeout.
REQ-029 STOP SHALL be absorbing: all strobes 0, and pc_o, stat_o and retired_o held; only reset exits.
REQ-030 Instructions that enter STOP, including halt, SHALL NOT increment retired_o.
REQ-031 Acks outside a request state SHALL be ignored.
REQ-032 imem_req_o and dmem_req_o SHALL never be asserted together.

Reset
REQ-033 When rst_n_i=0, all state SHALL clear immediately and asynchronously, including mid-request: state FETCH, pc_o=0, stat AOK, retired_o=0, counter 0, strobes 0.
REQ-034 After rst_n_i deasserts, imem_req_o SHALL assert in the first cycle.

Verification
REQ-035 nop (icode 1), valP=1, immediate acks -> FETCH,DECODE,EXECUTE,WRBACK,PCUPD sequence; pc_o=1; retired_o=1; reg_we_o=0.
REQ-036 jXX (icode 7), cnd=1, valC=0x40 -> pc_o=0x40; repeat with cnd=0, valP=0x49 -> pc_o=0x49.
REQ-037 mrmovq (icode 5), dmem_ack after 3 cycles -> dmem_req_o high 3 cycles with dmem_wr_o=0, reg_we_o pulses, retired_o increments; ret (icode 9) with valM=0x100 -> pc_o=0x100.
REQ-038 TIMEOUT=4, imem_ack_i never asserts -> STOP after 4 request cycles, stat_o=10, pc_o unchanged; ack exactly in cycle 4 -> normal DECODE.
REQ-039 halt (icode 0) -> stat_o=01, retired_o unchanged, STOP held for 20 cycles ignoring acks; instr_valid_i=0 -> stat_o=11.
REQ-040 rst_n_i pulsed low during MEMORY request -> outputs reset asynchronously the same cycle; FETCH resumes at PC 0.

Source files
------------

// File: rtl/y86_seq_ctrl_if.sv
// Bundle of fetch/memory handshakes, next-PC candidates and status outputs
// for the Y86 sequential controller. master = controller side, slave = datapath/memory side.
interface y86_seq_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);
  logic              imem_ack_i;
  logic [3:0]        icode_i;
  logic              instr_valid_i;
  logic              imem_error_i;
  logic              dmem_ack_i;
  logic              dmem_error_i;
  logic              cnd_i;
  logic [ADDR_W-1:0] valC_i;
  logic [ADDR_W-1:0] valP_i;
  logic [ADDR_W-1:0] valM_i;
  logic [ADDR_W-1:0] pc_o;
  logic              imem_req_o;
  logic              dmem_req_o;
  logic              dmem_wr_o;
  logic              cc_we_o;
  logic              reg_we_o;
  logic [1:0]        stat_o;
  logic [2:0]        state_o;
  logic [CNT_W-1:0]  retired_o;

  modport master (
    input  imem_ack_i, icode_i, instr_valid_i, imem_error_i,
           dmem_ack_i, dmem_error_i, cnd_i, valC_i, valP_i, valM_i,
    output pc_o, imem_req_o, dmem_req_o, dmem_wr_o, cc_we_o, reg_we_o,
           stat_o, state_o, retired_o
  );

  modport slave (
    output imem_ack_i, icode_i, instr_valid_i, imem_error_i,
           dmem_ack_i, dmem_error_i, cnd_i, valC_i, valP_i, valM_i,
    input  pc_o, imem_req_o, dmem_req_o, dmem_wr_o, cc_we_o, reg_we_o,
           stat_o, state_o, retired_o
  );
endinterface

// File: rtl/y86_seq_ctrl.sv
// Y86 sequential-processor controller: steps one instruction through
// fetch/decode/execute/memory/writeback/PC-update, with bounded memory waits
// and an absorbing STOP state carrying the final status code.
module y86_seq_ctrl #(
  parameter int ADDR_W  = 64,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  y86_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEMORY  = 3'd3,
    S_WRBACK  = 3'd4,
    S_PCUPD   = 3'd5,
    S_STOP    = 3'd6
  } state_e;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;
  localparam logic [7:0] TMO      = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        stat_q, stat_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [7:0]        wait_q, wait_d;
  logic [3:0]        icode_q, icode_d;
  logic [7:0]        wait_inc;
  logic              is_mem, is_wr, is_reg;

  assign wait_inc = wait_q + 8'd1;
  assign is_mem   = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  assign is_wr    = icode_q inside {4'h4, 4'h8, 4'hA};
  assign is_reg   = icode_q inside {4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};

  // State and architectural registers; everything clears the moment reset asserts.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      stat_q    <= STAT_AOK;
      retired_q <= '0;
      wait_q    <= '0;
      icode_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
      icode_q   <= icode_d;
    end
  end

  // Next-state logic; an ack in the cycle the wait count would hit TIMEOUT is honoured.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    wait_d    = wait_q;
    icode_d   = icode_q;
    case (state_q)
      S_FETCH: begin
        if (bus.imem_ack_i) begin
          wait_d  = '0;
          icode_d = bus.icode_i;
          if (bus.imem_error_i) begin
            state_d = S_STOP;
            stat_d  = STAT_ADR;
          end else if (!bus.instr_valid_i) begin
            state_d = S_STOP;
            stat_d  = STAT_INS;
          end else begin
            state_d = S_DECODE;
          end
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TMO) begin
            state_d = S_STOP;
            stat_d  = STAT_ADR;
          end
        end
      end
      S_DECODE: begin
        if (icode_q == 4'h0) begin
          state_d = S_STOP;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_mem) begin
          state_d = S_MEMORY;
          wait_d  = '0;
        end else begin
          state_d = S_WRBACK;
        end
      end
      S_MEMORY: begin
        if (bus.dmem_ack_i) begin
          wait_d = '0;
          if (bus.dmem_error_i) begin
            state_d = S_STOP;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_WRBACK;
          end
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TMO) begin
            state_d = S_STOP;
            stat_d  = STAT_ADR;
          end
        end
      end
      S_WRBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        case (icode_q)
          4'h8:    pc_d = bus.valC_i;
          4'h7:    pc_d = bus.cnd_i ? bus.valC_i : bus.valP_i;
          4'h9:    pc_d = bus.valM_i;
          default: pc_d = bus.valP_i;
        endcase
        retired_d = retired_q + CNT_W'(1);
        wait_d    = '0;
        state_d   = S_FETCH;
      end
      S_STOP:  state_d = S_STOP;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes decoded from the current state; fetch request is held off while reset is low.
  always_comb begin
    bus.imem_req_o = 1'b0;
    bus.dmem_req_o = 1'b0;
    bus.dmem_wr_o  = 1'b0;
    bus.cc_we_o    = 1'b0;
    bus.reg_we_o   = 1'b0;
    case (state_q)
      S_FETCH:   bus.imem_req_o = rst_n_i;
      S_EXECUTE: bus.cc_we_o    = (icode_q == 4'h6);
      S_MEMORY: begin
        bus.dmem_req_o = 1'b1;
        bus.dmem_wr_o  = is_wr;
      end
      S_WRBACK:  bus.reg_we_o   = is_reg;
      default:   bus.imem_req_o = 1'b0;
    endcase
  end

  assign bus.pc_o      = pc_q;
  assign bus.stat_o    = stat_q;
  assign bus.state_o   = state_q;
  assign bus.retired_o = retired_q;

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Directed self-checking bench for y86_seq_ctrl (TIMEOUT=4 so the wait limit is reachable).
module tb_y86_seq_ctrl;
  localparam int ADDR_W  = 64;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 4;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   overlap = 0;

  y86_seq_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  y86_seq_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  // Track any cycle where both memory requests are high
  always @(negedge clk_i) if (bus.imem_req_o && bus.dmem_req_o) overlap++;

  // Safety net against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    bus.imem_ack_i    = 1'b0;
    bus.icode_i       = 4'h0;
    bus.instr_valid_i = 1'b0;
    bus.imem_error_i  = 1'b0;
    bus.dmem_ack_i    = 1'b0;
    bus.dmem_error_i  = 1'b0;
    bus.cnd_i         = 1'b0;
    bus.valC_i        = '0;
    bus.valP_i        = '0;
    bus.valM_i        = '0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n_i = 1'b1;
  endtask

  // Present a successful fetch for one cycle; afterwards the DUT should sit in DECODE
  task automatic fetch_ack(input logic [3:0] ic);
    bus.imem_ack_i    = 1'b1;
    bus.icode_i       = ic;
    bus.instr_valid_i = 1'b1;
    tick();
    bus.imem_ack_i    = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2;
    n_cmp++; if (bus.state_o !== 3'd0) begin n_bad++; $display("[TB] FAIL reset_state: got %0d want 0", bus.state_o); end
    n_cmp++; if (bus.pc_o !== 64'd0) begin n_bad++; $display("[TB] FAIL reset_pc: got %0h want 0", bus.pc_o); end
    n_cmp++; if (bus.stat_o !== 2'b00 || bus.retired_o !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_stat_ret: got stat %0d ret %0d want 0 0", bus.stat_o, bus.retired_o); end
    n_cmp++; if (bus.imem_req_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_imem_req: got %b want 0", bus.imem_req_o); end
    tick();
    tick();
    rst_n_i = 1'b1;
    #1;
    n_cmp++; if (bus.imem_req_o !== 1'b1) begin n_bad++; $display("[TB] FAIL first_req: got %b want 1", bus.imem_req_o); end
  endtask

  task automatic test_nop();
    bus.valP_i = 64'd1;
    fetch_ack(4'h1);
    n_cmp++; if (bus.state_o !== 3'd1) begin n_bad++; $display("[TB] FAIL nop_decode: got %0d want 1", bus.state_o); end
    tick();
    n_cmp++; if (bus.state_o !== 3'd2 || bus.cc_we_o !== 1'b0) begin n_bad++; $display("[TB] FAIL nop_execute: got state %0d cc %b want 2 0", bus.state_o, bus.cc_we_o); end
    tick();
    n_cmp++; if (bus.state_o !== 3'd4 || bus.reg_we_o !== 1'b0) begin n_bad++; $display("[TB] FAIL nop_wrback: got state %0d reg_we %b want 4 0", bus.state_o, bus.reg_we_o); end
    tick();
    n_cmp++; if (bus.state_o !== 3'd5) begin n_bad++; $display("[TB] FAIL nop_pcupd: got %0d want 5", bus.state_o); end
    tick();
    n_cmp++; if (bus.state_o !== 3'd0 || bus.pc_o !== 64'd1 || bus.retired_o !== 32'd1) begin n_bad++; $display("[TB] FAIL nop_done: got state %0d pc %0h ret %0d want 0 1 1", bus.state_o, bus.pc_o, bus.retired_o); end
  endtask

  task automatic test_jxx();
    bus.valC_i = 64'h40; bus.valP_i = 64'h9; bus.cnd_i = 1'b1;
    fetch_ack(4'h7);
    tick();
    tick();
    n_cmp++; if (bus.state_o !== 3'd4) begin n_bad++; $display("[TB] FAIL jxx_no_memory: got %0d want 4", bus.state_o); end
    tick();
    tick();
    n_cmp++; if (bus.pc_o !== 64'h40 || bus.retired_o !== 32'd2) begin n_bad++; $display("[TB] FAIL jxx_taken: got pc %0h ret %0d want 40 2", bus.pc_o, bus.retired_o); end
    bus.cnd_i = 1'b0; bus.valP_i = 64'h49;
    fetch_ack(4'h7);
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (bus.pc_o !== 64'h49 || bus.retired_o !== 32'd3) begin n_bad++; $display("[TB] FAIL jxx_not_taken: got pc %0h ret %0d want 49 3", bus.pc_o, bus.retired_o); end
  endtask

  task automatic test_opq();
    bus.valP_i = 64'h4b;
    fetch_ack(4'h6);
    bus.dmem_ack_i = 1'b1;
    tick();
    n_cmp++; if (bus.state_o !== 3'd2 || bus.cc_we_o !== 1'b1) begin n_bad++; $display("[TB] FAIL opq_cc_we: got state %0d cc %b want 2 1", bus.state_o, bus.cc_we_o); end
    tick();
    n_cmp++; if (bus.state_o !== 3'd4 || bus.reg_we_o !== 1'b1 || bus.cc_we_o !== 1'b0) begin n_bad++; $display("[TB] FAIL opq_wrback: got state %0d reg %b cc %b want 4 1 0", bus.state_o, bus.reg_we_o, bus.cc_we_o); end
    bus.dmem_ack_i = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.pc_o !== 64'h4b || bus.retired_o !== 32'd4) begin n_bad++; $display("[TB] FAIL opq_done: got pc %0h ret %0d want 4b 4", bus.pc_o, bus.retired_o); end
  endtask

  task automatic test_mrmovq();
    int  req_cycles = 0;
    logic wr_seen   = 1'b0;
    bus.valP_i = 64'h55;
    fetch_ack(4'h5);
    tick();
    tick();
    n_cmp++; if (bus.state_o !== 3'd3) begin n_bad++; $display("[TB] FAIL mrmovq_memory: got %0d want 3", bus.state_o); end
    for (int i = 0; i < 8 && bus.state_o == 3'd3; i++) begin
      if (bus.dmem_req_o) req_cycles++;
      if (bus.dmem_wr_o) wr_seen = 1'b1;
      if (i == 2) bus.dmem_ack_i = 1'b1;
      tick();
      bus.dmem_ack_i = 1'b0;
    end
    n_cmp++; if (req_cycles != 3 || wr_seen !== 1'b0) begin n_bad++; $display("[TB] FAIL mrmovq_req: got %0d cycles wr %b want 3 0", req_cycles, wr_seen); end
    n_cmp++; if (bus.state_o !== 3'd4 || bus.reg_we_o !== 1'b1) begin n_bad++; $display("[TB] FAIL mrmovq_reg_we: got state %0d reg %b want 4 1", bus.state_o, bus.reg_we_o); end
    tick();
    n_cmp++; if (bus.reg_we_o !== 1'b0) begin n_bad++; $display("[TB] FAIL mrmovq_reg_pulse: got %b want 0", bus.reg_we_o); end
    tick();
    n_cmp++; if (bus.pc_o !== 64'h55 || bus.retired_o !== 32'd5) begin n_bad++; $display("[TB] FAIL mrmovq_done: got pc %0h ret %0d want 55 5", bus.pc_o, bus.retired_o); end
  endtask

  task automatic test_ret_call_rmmovq();
    bus.valM_i = 64'h100; bus.valP_i = 64'h60;
    fetch_ack(4'h9);
    tick();
    tick();
    n_cmp++; if (bus.dmem_req_o !== 1'b1 || bus.dmem_wr_o !== 1'b0) begin n_bad++; $display("[TB] FAIL ret_read: got req %b wr %b want 1 0", bus.dmem_req_o, bus.dmem_wr_o); end
    bus.dmem_ack_i = 1'b1;
    tick();
    bus.dmem_ack_i = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.pc_o !== 64'h100 || bus.retired_o !== 32'd6) begin n_bad++; $display("[TB] FAIL ret_pc: got pc %0h ret %0d want 100 6", bus.pc_o, bus.retired_o); end
    bus.valC_i = 64'h200; bus.valP_i = 64'h109;
    fetch_ack(4'h8);
    tick();
    tick();
    n_cmp++; if (bus.dmem_wr_o !== 1'b1) begin n_bad++; $display("[TB] FAIL call_write: got %b want 1", bus.dmem_wr_o); end
    bus.dmem_ack_i = 1'b1;
    tick();
    bus.dmem_ack_i = 1'b0;
    n_cmp++; if (bus.reg_we_o !== 1'b1) begin n_bad++; $display("[TB] FAIL call_reg_we: got %b want 1", bus.reg_we_o); end
    tick();
    tick();
    n_cmp++; if (bus.pc_o !== 64'h200 || bus.retired_o !== 32'd7) begin n_bad++; $display("[TB] FAIL call_pc: got pc %0h ret %0d want 200 7", bus.pc_o, bus.retired_o); end
    bus.valP_i = 64'h20a;
    fetch_ack(4'h4);
    tick();
    tick();
    n_cmp++; if (bus.dmem_wr_o !== 1'b1) begin n_bad++; $display("[TB] FAIL rmmovq_write: got %b want 1", bus.dmem_wr_o); end
    bus.dmem_ack_i = 1'b1;
    tick();
    bus.dmem_ack_i = 1'b0;
    n_cmp++; if (bus.reg_we_o !== 1'b0) begin n_bad++; $display("[TB] FAIL rmmovq_reg_we: got %b want 0", bus.reg_we_o); end
    tick();
    tick();
    n_cmp++; if (bus.pc_o !== 64'h20a || bus.retired_o !== 32'd8) begin n_bad++; $display("[TB] FAIL rmmovq_pc: got pc %0h ret %0d want 20a 8", bus.pc_o, bus.retired_o); end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    bus.valP_i = 64'h300;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (bus.state_o !== 3'd0 || bus.imem_req_o !== 1'b1) begin n_bad++; $display("[TB] FAIL wait_3_cycles: got state %0d req %b want 0 1", bus.state_o, bus.imem_req_o); end
    fetch_ack(4'h1);
    n_cmp++; if (bus.state_o !== 3'd1) begin n_bad++; $display("[TB] FAIL ack_wins_at_limit: got %0d want 1", bus.state_o); end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (bus.pc_o !== 64'h300 || bus.retired_o !== 32'd9) begin n_bad++; $display("[TB] FAIL ack_wins_done: got pc %0h ret %0d want 300 9", bus.pc_o, bus.retired_o); end
    for (int i = 0; i < 10 && bus.state_o == 3'd0; i++) begin
      if (bus.imem_req_o) req_cycles++;
      tick();
    end
    n_cmp++; if (req_cycles != 4) begin n_bad++; $display("[TB] FAIL timeout_cycles: got %0d want 4", req_cycles); end
    n_cmp++; if (bus.state_o !== 3'd6 || bus.stat_o !== 2'b10) begin n_bad++; $display("[TB] FAIL timeout_stop: got state %0d stat %0d want 6 2", bus.state_o, bus.stat_o); end
    n_cmp++; if (bus.pc_o !== 64'h300 || bus.retired_o !== 32'd9 || bus.imem_req_o !== 1'b0) begin n_bad++; $display("[TB] FAIL timeout_hold: got pc %0h ret %0d req %b want 300 9 0", bus.pc_o, bus.retired_o, bus.imem_req_o); end
  endtask

  task automatic test_halt();
    int bad_cycles = 0;
    do_reset();
    bus.valP_i = 64'h20;
    fetch_ack(4'h1);
    for (int i = 0; i < 4; i++) tick();
    fetch_ack(4'h0);
    tick();
    n_cmp++; if (bus.state_o !== 3'd6 || bus.stat_o !== 2'b01) begin n_bad++; $display("[TB] FAIL halt_stop: got state %0d stat %0d want 6 1", bus.state_o, bus.stat_o); end
    n_cmp++; if (bus.pc_o !== 64'h20 || bus.retired_o !== 32'd1) begin n_bad++; $display("[TB] FAIL halt_no_retire: got pc %0h ret %0d want 20 1", bus.pc_o, bus.retired_o); end
    bus.imem_ack_i = 1'b1; bus.dmem_ack_i = 1'b1; bus.icode_i = 4'h1; bus.instr_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.state_o !== 3'd6 || bus.imem_req_o || bus.dmem_req_o || bus.dmem_wr_o ||
          bus.cc_we_o || bus.reg_we_o) bad_cycles++;
    end
    clear_inputs();
    n_cmp++; if (bad_cycles != 0) begin n_bad++; $display("[TB] FAIL stop_absorbing: got %0d bad cycles want 0", bad_cycles); end
    n_cmp++; if (bus.pc_o !== 64'h20 || bus.stat_o !== 2'b01 || bus.retired_o !== 32'd1) begin n_bad++; $display("[TB] FAIL stop_hold: got pc %0h stat %0d ret %0d want 20 1 1", bus.pc_o, bus.stat_o, bus.retired_o); end
  endtask

  task automatic test_faults();
    do_reset();
    bus.imem_ack_i = 1'b1; bus.icode_i = 4'h1; bus.instr_valid_i = 1'b0;
    tick();
    clear_inputs();
    n_cmp++; if (bus.state_o !== 3'd6 || bus.stat_o !== 2'b11) begin n_bad++; $display("[TB] FAIL invalid_instr: got state %0d stat %0d want 6 3", bus.state_o, bus.stat_o); end
    do_reset();
    bus.imem_ack_i = 1'b1; bus.icode_i = 4'h1; bus.instr_valid_i = 1'b1; bus.imem_error_i = 1'b1;
    tick();
    clear_inputs();
    n_cmp++; if (bus.state_o !== 3'd6 || bus.stat_o !== 2'b10) begin n_bad++; $display("[TB] FAIL imem_error: got state %0d stat %0d want 6 2", bus.state_o, bus.stat_o); end
    do_reset();
    fetch_ack(4'h5);
    tick();
    tick();
    bus.dmem_ack_i = 1'b1; bus.dmem_error_i = 1'b1;
    tick();
    clear_inputs();
    n_cmp++; if (bus.state_o !== 3'd6 || bus.stat_o !== 2'b10 || bus.retired_o !== 32'd0) begin n_bad++; $display("[TB] FAIL dmem_error: got state %0d stat %0d ret %0d want 6 2 0", bus.state_o, bus.stat_o, bus.retired_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.valP_i = 64'h30;
    fetch_ack(4'h1);
    for (int i = 0; i < 4; i++) tick();
    fetch_ack(4'h5);
    tick();
    tick();
    n_cmp++; if (bus.dmem_req_o !== 1'b1 || bus.retired_o !== 32'd1) begin n_bad++; $display("[TB] FAIL pre_reset_memory: got req %b ret %0d want 1 1", bus.dmem_req_o, bus.retired_o); end
    #2;
    rst_n_i = 1'b0;
    #1;
    n_cmp++; if (bus.state_o !== 3'd0 || bus.dmem_req_o !== 1'b0 || bus.imem_req_o !== 1'b0) begin n_bad++; $display("[TB] FAIL async_reset_strobes: got state %0d dreq %b ireq %b want 0 0 0", bus.state_o, bus.dmem_req_o, bus.imem_req_o); end
    n_cmp++; if (bus.pc_o !== 64'd0 || bus.retired_o !== 32'd0 || bus.stat_o !== 2'b00) begin n_bad++; $display("[TB] FAIL async_reset_regs: got pc %0h ret %0d stat %0d want 0 0 0", bus.pc_o, bus.retired_o, bus.stat_o); end
    tick();
    rst_n_i = 1'b1;
    #1;
    n_cmp++; if (bus.imem_req_o !== 1'b1) begin n_bad++; $display("[TB] FAIL resume_fetch: got %b want 1", bus.imem_req_o); end
    bus.valP_i = 64'h8;
    fetch_ack(4'h1);
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (bus.pc_o !== 64'h8 || bus.retired_o !== 32'd1) begin n_bad++; $display("[TB] FAIL resume_done: got pc %0h ret %0d want 8 1", bus.pc_o, bus.retired_o); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_nop();
    test_jxx();
    test_opq();
    test_mrmovq();
    test_ret_call_rmmovq();
    test_timeout();
    test_halt();
    test_faults();
    test_async_reset();
    n_cmp++; if (overlap != 0) begin n_bad++; $display("[TB] FAIL req_exclusive: got %0d overlapping cycles want 0", overlap); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
